// File: rtl/pll_lock_sequencer_if.sv
// rtl/pll_lock_sequencer_if.sv - control/status bundle between the PLL lock sequencer and its environment
//
// Purpose: groups the PLL lock input, restart request and all sequencer status outputs.
// Ports (signals):
//   pll_lock   LOCK from PLL, asynchronous to the sequencer clock
//   restart    single-cycle request to restart the sequence
//   pll_rst    PLL RST, active high
//   sys_rstn   downstream datapath reset, active low
//   ready      PLL locked and qualified
//   fault      retries exhausted
//   state      0=RESET 1=WAIT 2=LOCKED 3=FAULT
//   retry_cnt  timeouts in the current sequence
//   loss_cnt   lock-loss events since reset, saturating at 255
// Modports: master = environment side, slave = sequencer side.
interface pll_lock_sequencer_if #(
  parameter int RETRY_W = 2
);
  logic               pll_lock;
  logic               restart;
  logic               pll_rst;
  logic               sys_rstn;
  logic               ready;
  logic               fault;
  logic [1:0]         state;
  logic [RETRY_W-1:0] retry_cnt;
  logic [7:0]         loss_cnt;

  modport master (
    output pll_lock, restart,
    input  pll_rst, sys_rstn, ready, fault, state, retry_cnt, loss_cnt
  );

  modport slave (
    input  pll_lock, restart,
    output pll_rst, sys_rstn, ready, fault, state, retry_cnt, loss_cnt
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - power-up/relock sequencer for the camera/pixel PLL
//
// Purpose: pulses PLL RST, qualifies a stable LOCK, then releases the downstream
// datapath reset. Restarts on loss of lock, parks in FAULT after repeated timeouts.
// Clocked by the free-running PLL reference clock, never by a PLL output.
// Ports:
//   clki  reference clock
//   rstn  asynchronous active-low reset
//   bus   pll_lock_sequencer_if.slave (pll_lock/restart in; pll_rst, sys_rstn, ready,
//         fault, state, retry_cnt, loss_cnt out)
module pll_lock_sequencer #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_FILTER  = 256,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int MAX_RETRY    = 3,
  parameter int SYNC_STAGES  = 2
) (
  input  logic clki,
  input  logic rstn,
  pll_lock_sequencer_if.slave bus
);

  localparam int RC_W    = $clog2(RST_CYCLES + 1);
  localparam int FILT_W  = $clog2(LOCK_FILTER + 1);
  localparam int TMO_W   = $clog2(LOCK_TIMEOUT + 1);
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [RC_W-1:0]        rst_cnt_q;
  logic [FILT_W-1:0]      filt_q;
  logic [TMO_W-1:0]       tmo_q;
  logic [RETRY_W-1:0]     retry_q;
  logic [7:0]             loss_q;
  logic                   pll_rst_q, sys_rstn_q, ready_q, fault_q;

  logic                   lock_s;
  logic [FILT_W-1:0]      filt_inc;
  logic [TMO_W-1:0]       tmo_inc;
  logic                   rst_done, filt_hit, tmo_hit;

  assign lock_s   = sync_q[SYNC_STAGES-1];
  assign filt_inc = filt_q + FILT_W'(1);
  assign tmo_inc  = tmo_q + TMO_W'(1);
  // Hits are evaluated on the incremented value so the transition lands on
  // exactly the Nth edge of the window.
  assign rst_done = (rst_cnt_q == RC_W'(RST_CYCLES - 1));
  assign filt_hit = lock_s && (filt_inc == FILT_W'(LOCK_FILTER));
  assign tmo_hit  = (tmo_inc == TMO_W'(LOCK_TIMEOUT));

  // Registered output image of each state: {pll_rst, sys_rstn, ready, fault}.
  // Loaded on the same edge as the state so outputs never lag the state.
  function automatic logic [3:0] outs_of(input state_t s);
    case (s)
      ST_RESET:  outs_of = 4'b1000;
      ST_WAIT:   outs_of = 4'b0000;
      ST_LOCKED: outs_of = 4'b0110;
      default:   outs_of = 4'b1001; // FAULT keeps the PLL held in reset
    endcase
  endfunction

  always_ff @(posedge clki or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_RESET;
      sync_q     <= '0;
      rst_cnt_q  <= '0;
      filt_q     <= '0;
      tmo_q      <= '0;
      retry_q    <= '0;
      loss_q     <= '0;
      {pll_rst_q, sys_rstn_q, ready_q, fault_q} <= outs_of(ST_RESET);
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_lock};

      if (bus.restart) begin
        // Highest priority from any state; loss history is preserved.
        state_q   <= ST_RESET;
        rst_cnt_q <= '0;
        filt_q    <= '0;
        tmo_q     <= '0;
        retry_q   <= '0;
        {pll_rst_q, sys_rstn_q, ready_q, fault_q} <= outs_of(ST_RESET);
      end else begin
        case (state_q)
          ST_RESET: begin
            if (rst_done) begin
              state_q <= ST_WAIT;
              filt_q  <= '0;
              tmo_q   <= '0;
              {pll_rst_q, sys_rstn_q, ready_q, fault_q} <= outs_of(ST_WAIT);
            end else begin
              rst_cnt_q <= rst_cnt_q + RC_W'(1);
            end
          end

          ST_WAIT: begin
            if (filt_hit) begin
              // Lock qualification beats a timeout on the same edge.
              state_q <= ST_LOCKED;
              retry_q <= '0;
              {pll_rst_q, sys_rstn_q, ready_q, fault_q} <= outs_of(ST_LOCKED);
            end else if (tmo_hit) begin
              if (retry_q == RETRY_W'(MAX_RETRY)) begin
                state_q <= ST_FAULT;
                {pll_rst_q, sys_rstn_q, ready_q, fault_q} <= outs_of(ST_FAULT);
              end else begin
                state_q   <= ST_RESET;
                rst_cnt_q <= '0;
                retry_q   <= retry_q + RETRY_W'(1);
                {pll_rst_q, sys_rstn_q, ready_q, fault_q} <= outs_of(ST_RESET);
              end
            end else begin
              tmo_q  <= tmo_inc;
              filt_q <= lock_s ? filt_inc : '0;
            end
          end

          ST_LOCKED: begin
            if (!lock_s) begin
              state_q   <= ST_RESET;
              rst_cnt_q <= '0;
              if (loss_q != 8'hFF) loss_q <= loss_q + 8'd1;
              {pll_rst_q, sys_rstn_q, ready_q, fault_q} <= outs_of(ST_RESET);
            end
          end

          default: begin
            // FAULT: parked until restart or rstn.
          end
        endcase
      end
    end
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.sys_rstn  = sys_rstn_q;
  assign bus.ready     = ready_q;
  assign bus.fault     = fault_q;
  assign bus.state     = state_q;
  assign bus.retry_cnt = retry_q;
  assign bus.loss_cnt  = loss_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - self-checking bench for pll_lock_sequencer
module tb_pll_lock_sequencer;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  pll_lock_sequencer_if #(.RETRY_W(2)) bus ();

  pll_lock_sequencer #(
    .RST_CYCLES  (4),
    .LOCK_FILTER (8),
    .LOCK_TIMEOUT(100),
    .MAX_RETRY   (2),
    .SYNC_STAGES (2)
  ) dut (
    .clki(clk),
    .rstn(rstn),
    .bus (bus.slave)
  );

  // Observation vector: {state, pll_rst, sys_rstn, ready, fault, retry_cnt, loss_cnt}
  logic [15:0] obs_w;
  assign obs_w = {bus.state, bus.pll_rst, bus.sys_rstn, bus.ready, bus.fault,
                  bus.retry_cnt, bus.loss_cnt};

  typedef struct {
    string       nm;
    int          dly;
    logic [15:0] o;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          total = 0;
  int          bad = 0;
  int          exp_loss = 0;
  int          d;
  logic [15:0] o;

  function automatic logic [15:0] mk(input int st, input bit prst, input bit srst,
                                     input bit rdy, input bit flt, input int rty,
                                     input int loss);
    logic [1:0] s2;
    logic [1:0] r2;
    logic [7:0] l8;
    s2 = st[1:0];
    r2 = rty[1:0];
    l8 = loss[7:0];
    return {s2, prst, srst, rdy, flt, r2, l8};
  endfunction

  function automatic void push(input string nm, input int dly, input logic [15:0] ov);
    exp_t x;
    x.nm  = nm;
    x.dly = dly;
    x.o   = ov;
    exp_q.push_back(x);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for the next change of any output; dly = edges waited, -1 if none.
  task automatic next_change(input int budget, output int dly, output logic [15:0] ov);
    logic [15:0] prev;
    prev = obs_w;
    dly  = -1;
    ov   = prev;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk);
      #1;
      if (obs_w !== prev) begin
        dly = i;
        ov  = obs_w;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.pll_lock = 1'b0;
    bus.restart  = 1'b0;
    tick(3);
    total++;
    if (obs_w !== mk(0, 1, 0, 0, 0, 0, 0)) begin
      bad++;
      $display("FAIL reset_values: got %h want %h", obs_w, mk(0, 1, 0, 0, 0, 0, 0));
    end
    bus.pll_lock = 1'b1;
    rstn = 1'b1;
    push("reset_to_wait", 4, mk(1, 0, 0, 0, 0, 0, 0));
    e = exp_q.pop_front(); next_change(e.dly + 4, d, o); total++;
    if (d != e.dly || o !== e.o) begin bad++;
      $display("FAIL %s: got dly=%0d obs=%h want dly=%0d obs=%h", e.nm, d, o, e.dly, e.o); end
  endtask

  task automatic test_normal_lock();
    push("normal_lock", 8, mk(2, 0, 1, 1, 0, 0, exp_loss));
    e = exp_q.pop_front(); next_change(e.dly + 4, d, o); total++;
    if (d != e.dly || o !== e.o) begin bad++;
      $display("FAIL %s: got dly=%0d obs=%h want dly=%0d obs=%h", e.nm, d, o, e.dly, e.o); end
  endtask

  task automatic test_glitch_lock();
    bus.pll_lock = 1'b0;
    bus.restart  = 1'b1;
    push("glitch_restart", 1, mk(0, 1, 0, 0, 0, 0, exp_loss));
    e = exp_q.pop_front(); next_change(e.dly + 4, d, o); total++;
    if (d != e.dly || o !== e.o) begin bad++;
      $display("FAIL %s: got dly=%0d obs=%h want dly=%0d obs=%h", e.nm, d, o, e.dly, e.o); end
    bus.restart = 1'b0;
    push("glitch_wait", 4, mk(1, 0, 0, 0, 0, 0, exp_loss));
    e = exp_q.pop_front(); next_change(e.dly + 4, d, o); total++;
    if (d != e.dly || o !== e.o) begin bad++;
      $display("FAIL %s: got dly=%0d obs=%h want dly=%0d obs=%h", e.nm, d, o, e.dly, e.o); end
    // lock_s high for 7 WAIT edges, low for 1, then high: re-rise is 10 edges
    // after entering WAIT, lock declared 8 edges later (18 after WAIT entry).
    bus.pll_lock = 1'b1;
    tick(7);
    bus.pll_lock = 1'b0;
    tick(1);
    bus.pll_lock = 1'b1;
    push("glitch_lock", 10, mk(2, 0, 1, 1, 0, 0, exp_loss));
    e = exp_q.pop_front(); next_change(e.dly + 4, d, o); total++;
    if (d != e.dly || o !== e.o) begin bad++;
      $display("FAIL %s: got dly=%0d obs=%h want dly=%0d obs=%h", e.nm, d, o, e.dly, e.o); end
  endtask

  task automatic test_retry_fault();
    bus.pll_lock = 1'b0;
    bus.restart  = 1'b1;
    push("rf_restart", 1, mk(0, 1, 0, 0, 0, 0, exp_loss));
    e = exp_q.pop_front(); next_change(e.dly + 4, d, o); total++;
    if (d != e.dly || o !== e.o) begin bad++;
      $display("FAIL %s: got dly=%0d obs=%h want dly=%0d obs=%h", e.nm, d, o, e.dly, e.o); end
    bus.restart = 1'b0;
    push("rf_wait0", 4, mk(1, 0, 0, 0, 0, 0, exp_loss));
    push("rf_tmo1", 100, mk(0, 1, 0, 0, 0, 1, exp_loss));
    push("rf_wait1", 4, mk(1, 0, 0, 0, 0, 1, exp_loss));
    push("rf_tmo2", 100, mk(0, 1, 0, 0, 0, 2, exp_loss));
    push("rf_wait2", 4, mk(1, 0, 0, 0, 0, 2, exp_loss));
    push("rf_fault", 100, mk(3, 1, 0, 0, 1, 2, exp_loss));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); next_change(e.dly + 4, d, o); total++;
      if (d != e.dly || o !== e.o) begin bad++;
        $display("FAIL %s: got dly=%0d obs=%h want dly=%0d obs=%h", e.nm, d, o, e.dly, e.o); end
    end
    next_change(150, d, o);
    total++;
    if (d != -1) begin
      bad++;
      $display("FAIL fault_held: left FAULT after %0d edges obs=%h, want no change", d, o);
    end
    bus.pll_lock = 1'b1;
    bus.restart  = 1'b1;
    push("fault_restart", 1, mk(0, 1, 0, 0, 0, 0, exp_loss));
    e = exp_q.pop_front(); next_change(e.dly + 4, d, o); total++;
    if (d != e.dly || o !== e.o) begin bad++;
      $display("FAIL %s: got dly=%0d obs=%h want dly=%0d obs=%h", e.nm, d, o, e.dly, e.o); end
    bus.restart = 1'b0;
    push("fr_wait", 4, mk(1, 0, 0, 0, 0, 0, exp_loss));
    push("fr_lock", 8, mk(2, 0, 1, 1, 0, 0, exp_loss));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); next_change(e.dly + 4, d, o); total++;
      if (d != e.dly || o !== e.o) begin bad++;
        $display("FAIL %s: got dly=%0d obs=%h want dly=%0d obs=%h", e.nm, d, o, e.dly, e.o); end
    end
  endtask

  // One-cycle LOCK drop in LOCKED: RESET 3 edges after the drop, 4-cycle PLL_RST, relock.
  task automatic test_loss_of_lock(input int n);
    for (int k = 0; k < n; k++) begin
      bus.pll_lock = 1'b0;
      tick(1);
      bus.pll_lock = 1'b1;
      exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
      push("loss_reset", 2, mk(0, 1, 0, 0, 0, 0, exp_loss));
      push("loss_wait", 4, mk(1, 0, 0, 0, 0, 0, exp_loss));
      push("loss_relock", 8, mk(2, 0, 1, 1, 0, 0, exp_loss));
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); next_change(e.dly + 4, d, o); total++;
        if (d != e.dly || o !== e.o) begin bad++;
          $display("FAIL %s[%0d]: got dly=%0d obs=%h want dly=%0d obs=%h", e.nm, k, d, o, e.dly, e.o); end
      end
    end
  endtask

  task automatic test_tie();
    bus.pll_lock = 1'b0;
    bus.restart  = 1'b1;
    push("tie_restart", 1, mk(0, 1, 0, 0, 0, 0, exp_loss));
    e = exp_q.pop_front(); next_change(e.dly + 4, d, o); total++;
    if (d != e.dly || o !== e.o) begin bad++;
      $display("FAIL %s: got dly=%0d obs=%h want dly=%0d obs=%h", e.nm, d, o, e.dly, e.o); end
    bus.restart = 1'b0;
    push("tie_wait0", 4, mk(1, 0, 0, 0, 0, 0, exp_loss));
    push("tie_tmo1", 100, mk(0, 1, 0, 0, 0, 1, exp_loss));
    push("tie_wait1", 4, mk(1, 0, 0, 0, 0, 1, exp_loss));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); next_change(e.dly + 4, d, o); total++;
      if (d != e.dly || o !== e.o) begin bad++;
        $display("FAIL %s: got dly=%0d obs=%h want dly=%0d obs=%h", e.nm, d, o, e.dly, e.o); end
    end
    // LOCK captured on WAIT edge 91 -> lock_s high on edges 93..100 -> filter hits 8 on edge 100.
    tick(90);
    bus.pll_lock = 1'b1;
    push("tie_lock_wins", 10, mk(2, 0, 1, 1, 0, 0, exp_loss));
    e = exp_q.pop_front(); next_change(e.dly + 4, d, o); total++;
    if (d != e.dly || o !== e.o) begin bad++;
      $display("FAIL %s: got dly=%0d obs=%h want dly=%0d obs=%h", e.nm, d, o, e.dly, e.o); end
  endtask

  task automatic test_async_reset();
    bus.pll_lock = 1'b0;
    bus.restart  = 1'b1;
    push("ar_restart", 1, mk(0, 1, 0, 0, 0, 0, exp_loss));
    e = exp_q.pop_front(); next_change(e.dly + 4, d, o); total++;
    if (d != e.dly || o !== e.o) begin bad++;
      $display("FAIL %s: got dly=%0d obs=%h want dly=%0d obs=%h", e.nm, d, o, e.dly, e.o); end
    bus.restart = 1'b0;
    push("ar_wait", 4, mk(1, 0, 0, 0, 0, 0, exp_loss));
    e = exp_q.pop_front(); next_change(e.dly + 4, d, o); total++;
    if (d != e.dly || o !== e.o) begin bad++;
      $display("FAIL %s: got dly=%0d obs=%h want dly=%0d obs=%h", e.nm, d, o, e.dly, e.o); end
    tick(5);
    #3;
    rstn = 1'b0;
    #1;
    exp_loss = 0;
    total++;
    if (obs_w !== mk(0, 1, 0, 0, 0, 0, 0)) begin
      bad++;
      $display("FAIL async_reset_mid_wait: got %h want %h", obs_w, mk(0, 1, 0, 0, 0, 0, 0));
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    push("ar_release_wait", 4, mk(1, 0, 0, 0, 0, 0, 0));
    e = exp_q.pop_front(); next_change(e.dly + 4, d, o); total++;
    if (d != e.dly || o !== e.o) begin bad++;
      $display("FAIL %s: got dly=%0d obs=%h want dly=%0d obs=%h", e.nm, d, o, e.dly, e.o); end
  endtask

  initial begin
    test_reset();
    test_normal_lock();
    test_glitch_lock();
    test_retry_fault();
    test_loss_of_lock(1);
    test_loss_of_lock(300);
    test_tie();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
